// File: rtl/rgmii_to_gmii_pkg.sv
// Shared definitions for the RGMII receive path: frame FSM states,
// preamble/SFD byte values and in-band link status layout.
package rgmii_to_gmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // In-band status nibble layout (sent by the PHY during inter-frame idle)
    localparam int STAT_LINK_BIT   = 0;
    localparam int STAT_SPEED_LSB  = 1;
    localparam int STAT_DUPLEX_BIT = 3;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

endpackage

// File: rtl/rgmii_to_gmii_ddio_in_x5.sv
// Five-bit DDR input capture. The rising-edge half and the falling-edge
// half are both re-registered so they leave aligned to the next rising edge.
module ddio_in_x5 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] datain,
    output logic [4:0] dataout_h,
    output logic [4:0] dataout_l
);

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_bit
            logic r_h_cap;
            logic r_l_cap;
            logic r_h_out;
            logic r_l_out;

            // Capture the rising-edge half of the bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_h_cap <= 1'b0;
                else        r_h_cap <= datain[gi];
            end

            // Capture the falling-edge half of the bit
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) r_l_cap <= 1'b0;
                else        r_l_cap <= datain[gi];
            end

            // Re-time both halves onto the following rising edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_h_out <= 1'b0;
                    r_l_out <= 1'b0;
                end else begin
                    r_h_out <= r_h_cap;
                    r_l_out <= r_l_cap;
                end
            end

            assign dataout_h[gi] = r_h_out;
            assign dataout_l[gi] = r_l_out;
        end
    endgenerate

endmodule

// File: rtl/rgmii_to_gmii.sv
// RGMII receive to GMII: rebuilds the byte stream, strips preamble/SFD,
// frames the payload with sof/eof/err strobes and decodes in-band status.
module rgmii_to_gmii
    import rgmii_to_gmii_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int PREAMBLE_MAX  = 7
) (
    input  logic        rgmii_rx_clk,
    input  logic        rst_n,
    input  logic        rgmii_rx_ctl,
    input  logic [3:0]  rgmii_rxd,
    output logic        gmii_rx_clk,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    output logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [15:0] rx_byte_cnt,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        full_duplex
);

    localparam logic [7:0]  PRE_MAX_C = 8'(PREAMBLE_MAX);
    localparam logic [15:0] MIN_LEN_C = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN_C = 16'(MAX_FRAME_LEN);

    assign gmii_rx_clk = rgmii_rx_clk;

    // DDR capture
    logic [4:0] w_cap_h;
    logic [4:0] w_cap_l;
    logic [7:0] w_cap_byte;
    logic       w_cap_dv;
    logic       w_cap_er;

    ddio_in_x5 u_ddio (
        .clk       (rgmii_rx_clk),
        .rst_n     (rst_n),
        .datain    ({rgmii_rx_ctl, rgmii_rxd}),
        .dataout_h (w_cap_h),
        .dataout_l (w_cap_l)
    );

    assign w_cap_byte = {w_cap_l[3:0], w_cap_h[3:0]};
    assign w_cap_dv   = w_cap_h[4];
    assign w_cap_er   = w_cap_h[4] ^ w_cap_l[4];

    // Raw GMII stage
    logic       r_gmii_dv;
    logic       r_gmii_er;
    logic [7:0] r_gmii_rxd;

    // Register the rebuilt byte as the raw GMII output
    always_ff @(posedge rgmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gmii_dv  <= 1'b0;
            r_gmii_er  <= 1'b0;
            r_gmii_rxd <= 8'h00;
        end else begin
            r_gmii_dv  <= w_cap_dv;
            r_gmii_er  <= w_cap_er;
            r_gmii_rxd <= w_cap_byte;
        end
    end

    assign gmii_rx_dv = r_gmii_dv;
    assign gmii_rx_er = r_gmii_er;
    assign gmii_rxd   = r_gmii_rxd;

    // In-band status: a nibble is accepted only when repeated on two
    // back-to-back idle cycles, which filters single-cycle glitches.
    logic       w_stat_cycle;
    logic [3:0] w_stat_nib;
    logic [3:0] r_prev_nib;
    logic       r_prev_vld;
    logic       r_link_up;
    logic [1:0] r_link_speed;
    logic       r_full_duplex;

    assign w_stat_cycle = !r_gmii_dv && !r_gmii_er;
    assign w_stat_nib   = r_gmii_rxd[3:0];

    // Track the previous idle nibble and latch status on a repeat
    always_ff @(posedge rgmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_nib    <= 4'h0;
            r_prev_vld    <= 1'b0;
            r_link_up     <= 1'b0;
            r_link_speed  <= 2'b00;
            r_full_duplex <= 1'b0;
        end else if (w_stat_cycle) begin
            r_prev_nib <= w_stat_nib;
            r_prev_vld <= 1'b1;
            if (r_prev_vld && (r_prev_nib == w_stat_nib)) begin
                r_link_up     <= w_stat_nib[STAT_LINK_BIT];
                r_link_speed  <= w_stat_nib[STAT_SPEED_LSB +: 2];
                r_full_duplex <= w_stat_nib[STAT_DUPLEX_BIT];
            end
        end else begin
            r_prev_vld <= 1'b0;
        end
    end

    assign link_up     = r_link_up;
    assign link_speed  = r_link_speed;
    assign full_duplex = r_full_duplex;

    // Frame FSM state and per-frame bookkeeping
    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [7:0]  r_pre_cnt;
    logic [7:0]  w_pre_cnt_next;
    logic [15:0] r_len;
    logic [15:0] w_len_next;
    logic [15:0] w_len_inc;
    logic        r_err_flag;
    logic        w_err_next;
    logic        r_sof_pend;
    logic        w_sof_pend_next;
    logic        w_out_valid;
    logic        w_out_sof;
    logic        w_out_eof;
    logic        w_out_err;

    assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;

    // State and counter registers
    always_ff @(posedge rgmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= 8'd0;
            r_len      <= 16'd0;
            r_err_flag <= 1'b0;
            r_sof_pend <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pre_cnt  <= w_pre_cnt_next;
            r_len      <= w_len_next;
            r_err_flag <= w_err_next;
            r_sof_pend <= w_sof_pend_next;
        end
    end

    // Next state and payload strobes; the next byte's dv (one stage
    // earlier in the capture path) tells us whether this byte is the last.
    always_comb begin
        w_state_next    = r_state;
        w_pre_cnt_next  = r_pre_cnt;
        w_len_next      = r_len;
        w_err_next      = r_err_flag;
        w_sof_pend_next = r_sof_pend;
        w_out_valid     = 1'b0;
        w_out_sof       = 1'b0;
        w_out_eof       = 1'b0;
        w_out_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_gmii_dv) begin
                    if (r_gmii_rxd == PREAMBLE_BYTE) begin
                        w_state_next   = ST_PREAMBLE;
                        w_pre_cnt_next = 8'd1;
                    end else if (r_gmii_rxd == SFD_BYTE) begin
                        w_state_next    = ST_DATA;
                        w_len_next      = 16'd0;
                        w_err_next      = 1'b0;
                        w_sof_pend_next = 1'b1;
                    end else begin
                        w_state_next = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!r_gmii_dv) begin
                    w_state_next = ST_IDLE;
                end else if (r_gmii_rxd == PREAMBLE_BYTE) begin
                    if (r_pre_cnt >= PRE_MAX_C) w_state_next = ST_DROP;
                    else                        w_pre_cnt_next = r_pre_cnt + 8'd1;
                end else if (r_gmii_rxd == SFD_BYTE) begin
                    w_state_next    = ST_DATA;
                    w_len_next      = 16'd0;
                    w_err_next      = 1'b0;
                    w_sof_pend_next = 1'b1;
                end else begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!r_gmii_dv) begin
                    w_state_next    = ST_IDLE;
                    w_sof_pend_next = 1'b0;
                end else begin
                    w_out_valid     = 1'b1;
                    w_out_sof       = r_sof_pend;
                    w_sof_pend_next = 1'b0;
                    w_len_next      = w_len_inc;
                    w_err_next      = r_err_flag | r_gmii_er | (w_len_inc > MAX_LEN_C);
                    w_out_eof       = !w_cap_dv;
                    w_out_err       = w_out_eof & (w_err_next | (w_len_inc < MIN_LEN_C));
                end
            end
            ST_DROP: begin
                if (!r_gmii_dv) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Payload output register
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_sof;
    logic        r_rx_eof;
    logic        r_rx_err;
    logic [15:0] r_rx_byte_cnt;

    // Register payload byte, strobes and the length reported at eof
    always_ff @(posedge rgmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_rx_sof      <= 1'b0;
            r_rx_eof      <= 1'b0;
            r_rx_err      <= 1'b0;
            r_rx_byte_cnt <= 16'd0;
        end else begin
            r_rx_valid <= w_out_valid;
            r_rx_sof   <= w_out_sof;
            r_rx_eof   <= w_out_eof;
            r_rx_err   <= w_out_err;
            if (w_out_valid) r_rx_data <= r_gmii_rxd;
            if (w_out_eof)   r_rx_byte_cnt <= w_len_inc;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_sof      = r_rx_sof;
    assign rx_eof      = r_rx_eof;
    assign rx_err      = r_rx_err;
    assign rx_byte_cnt = r_rx_byte_cnt;

endmodule
